// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the I-cache and D-cache miss paths.
// One transaction in flight at a time; D has priority, bounded by a streak limit
// so a waiting instruction fetch always makes forward progress.
module mem_arbiter #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned LINE_W       = 64,
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_valid,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_req_ready,
    output logic              i_resp_valid,
    output logic [LINE_W-1:0] i_resp_data,
    input  logic              d_req_valid,
    input  logic              d_req_write,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [LINE_W-1:0] d_req_wdata,
    output logic              d_req_ready,
    output logic              d_resp_valid,
    output logic [LINE_W-1:0] d_resp_data,
    output logic              mem_req_valid,
    output logic              mem_req_write,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [LINE_W-1:0] mem_req_wdata,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [LINE_W-1:0] mem_resp_data,
    output logic              busy,
    output logic              owner
);

    localparam int unsigned STREAK_W = $clog2(MAX_D_STREAK + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2
    } state_t;

    state_t              state;
    logic [STREAK_W-1:0] streak;
    logic                lat_write;
    logic                lat_owner;
    logic [ADDR_W-1:0]   lat_addr;
    logic [LINE_W-1:0]   lat_wdata;
    logic                grant_i;
    logic                grant_d;
    logic                streak_full;

    // Arbitration: D wins unless it has starved a waiting I request for MAX_D_STREAK grants
    always_comb begin
        streak_full = (streak == STREAK_W'(MAX_D_STREAK));
        grant_d     = d_req_valid && !(i_req_valid && streak_full);
        grant_i     = i_req_valid && !grant_d;
    end

    // Handshake and memory-side outputs decode straight from the registered state and latches
    assign i_req_ready   = !rst && (state == IDLE) && grant_i;
    assign d_req_ready   = !rst && (state == IDLE) && grant_d;
    assign mem_req_valid = (state == ISSUE);
    assign mem_req_write = lat_write;
    assign mem_req_addr  = lat_addr;
    assign mem_req_wdata = lat_wdata;
    assign busy          = (state != IDLE);
    assign owner         = lat_owner;

    // Transaction FSM: grant/latch, issue to memory, then route the response to its owner
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            streak       <= '0;
            lat_write    <= 1'b0;
            lat_owner    <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            i_resp_valid <= 1'b0;
            i_resp_data  <= '0;
            d_resp_valid <= 1'b0;
            d_resp_data  <= '0;
        end else begin
            i_resp_valid <= 1'b0;
            i_resp_data  <= '0;
            d_resp_valid <= 1'b0;
            d_resp_data  <= '0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        lat_owner <= 1'b1;
                        lat_write <= d_req_write;
                        lat_addr  <= d_req_addr;
                        lat_wdata <= d_req_wdata;
                        state     <= ISSUE;
                        if (!i_req_valid) begin
                            streak <= '0;
                        end else if (!streak_full) begin
                            streak <= streak + STREAK_W'(1);
                        end
                    end else if (grant_i) begin
                        lat_owner <= 1'b0;
                        lat_write <= 1'b0;
                        lat_addr  <= i_req_addr;
                        lat_wdata <= '0;
                        streak    <= '0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_req_ready) begin
                        if (lat_write) begin
                            d_resp_valid <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            state <= WAIT_RESP;
                        end
                    end
                end
                WAIT_RESP: begin
                    if (mem_resp_valid) begin
                        if (lat_owner) begin
                            d_resp_valid <= 1'b1;
                            d_resp_data  <= mem_resp_data;
                        end else begin
                            i_resp_valid <= 1'b1;
                            i_resp_data  <= mem_resp_data;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
